// File: rtl/ascii_hex_parser_if.sv
// Character-in / value-out handshake bundle for the ASCII hex parser.
// The slave modport is the parser; the master modport is whoever feeds
// characters and consumes results.
interface ascii_hex_parser_if #(
    parameter int DIGITS = 8
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_value;
    logic [CW-1:0] out_ndigits;
    logic          out_err;

    modport slave (
        input  in_valid,
        input  in_char,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_value,
        output out_ndigits,
        output out_err
    );

    modport master (
        output in_valid,
        output in_char,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  out_ndigits,
        input  out_err
    );
endinterface

// File: rtl/ascii_hex_parser.sv
// ASCII hex string decoder: accumulates hex digits into a right-aligned
// binary value and presents it with a digit count and an error flag.
// Blanks before a value are skipped, backspace removes the last digit,
// and any illegal character poisons the string until its terminator.
module ascii_hex_parser #(
    parameter int DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ascii_hex_parser_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SKIP  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [W-1:0]  acc_reg;
    logic [CW-1:0] cnt_reg;
    logic          err_reg;

    logic          is_digit;
    logic          is_term;
    logic          is_bs;
    logic [3:0]    nibble;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_dec;

    // Classify the incoming character and map hex digits to their nibble.
    always_comb begin
        is_digit = 1'b0;
        is_term  = 1'b0;
        is_bs    = 1'b0;
        nibble   = 4'd0;
        if (bus.in_char >= 8'h30 && bus.in_char <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = bus.in_char[3:0];
        end else if ((bus.in_char >= 8'h41 && bus.in_char <= 8'h46) ||
                     (bus.in_char >= 8'h61 && bus.in_char <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
            is_digit = 1'b1;
            nibble   = bus.in_char[3:0] + 4'd9;
        end else if (bus.in_char == 8'h0D || bus.in_char == 8'h0A ||
                     bus.in_char == 8'h20) begin
            is_term = 1'b1;
        end else if (bus.in_char == 8'h08) begin
            is_bs = 1'b1;
        end
    end

    assign cnt_inc = cnt_reg + CW'(1);
    assign cnt_dec = cnt_reg - CW'(1);

    // Parser state machine; every non-HOLD state accepts a character, so
    // in_valid alone qualifies a handshake there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_digit) begin
                            acc_reg   <= W'(nibble);
                            cnt_reg   <= CW'(1);
                            // A one-digit parser is already full here.
                            state_reg <= (DIGITS == 1) ? HOLD : ACCUM;
                        end else if (!is_term && !is_bs) begin
                            state_reg <= SKIP;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (is_digit) begin
                            acc_reg <= (acc_reg << 4) | W'(nibble);
                            cnt_reg <= cnt_inc;
                            if (cnt_inc == CW'(DIGITS)) begin
                                state_reg <= HOLD;
                            end
                        end else if (is_term) begin
                            state_reg <= HOLD;
                        end else if (is_bs) begin
                            acc_reg <= acc_reg >> 4;
                            cnt_reg <= cnt_dec;
                            if (cnt_dec == '0) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            state_reg <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (bus.in_valid && is_term) begin
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        err_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure state decodes; result fields come straight
    // from the accumulator registers.
    assign bus.in_ready    = (state_reg != HOLD);
    assign bus.out_valid   = (state_reg == HOLD);
    assign bus.out_value   = acc_reg;
    assign bus.out_ndigits = cnt_reg;
    assign bus.out_err     = err_reg;
endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for ascii_hex_parser: expected results are queued as
// strings are sent and a monitor pops and compares on each output transfer.
module tb_ascii_hex_parser;
    localparam int DIGITS = 8;

    typedef struct packed {
        logic [31:0] value;
        logic [3:0]  ndigits;
        logic        err;
    } result_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ascii_hex_parser_if #(.DIGITS(DIGITS)) bus ();

    ascii_hex_parser #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    result_t sb[$];
    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_result(input logic [31:0] v, input logic [3:0] n, input logic e);
        result_t r;
        r.value = v;
        r.ndigits = n;
        r.err = e;
        sb.push_back(r);
    endtask

    // Called at a falling edge; returns at the falling edge after the
    // character has been accepted, with in_valid dropped.
    task automatic send(input logic [7:0] c);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: char 0x%0h not accepted in 200 cycles", c);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Monitor: one scoreboard pop per output handshake.
    initial begin
        result_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                $display("xfer value=0x%0h ndigits=%0d err=%0b",
                         bus.out_value, bus.out_ndigits, bus.out_err);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_output: got value 0x%0h with empty scoreboard",
                             bus.out_value);
                end else begin
                    r = sb.pop_front();
                    chk("out_value", 64'(bus.out_value), 64'(r.value));
                    chk("out_ndigits", 64'(bus.out_ndigits), 64'(r.ndigits));
                    chk("out_err", 64'(bus.out_err), 64'(r.err));
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_char   = 8'h35;   // offered during reset, must not be consumed
        bus.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_value", 64'(bus.out_value), 64'd0);
        chk("rst_out_ndigits", 64'(bus.out_ndigits), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 1: mixed case, one-cycle result pulse
        expect_result(32'h1AF, 4'd3, 1'b0);
        send("1"); send("a"); send("F"); send(8'h0D);
        chk("t1_valid_first", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        chk("t1_valid_second", 64'(bus.out_valid), 64'd0);

        // 2: auto-terminate at DIGITS with backpressure
        bus.out_ready = 1'b0;
        expect_result(32'hDEADBEEF, 4'd8, 1'b0);
        expect_result(32'h1, 4'd1, 1'b0);
        send("D"); send("E"); send("A"); send("D");
        send("B"); send("E"); send("E"); send("F");
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
        fork
            send("1");
            begin
                repeat (3) @(negedge clk);
                chk("t2_hold_value", 64'(bus.out_value), 64'hDEADBEEF);
                chk("t2_hold_in_ready", 64'(bus.in_ready), 64'd0);
                bus.out_ready = 1'b1;
            end
        join
        send(8'h0D);

        // 3: illegal character poisons the string
        expect_result(32'h0, 4'd0, 1'b1);
        expect_result(32'h4, 4'd1, 1'b0);
        send("1"); send("2"); send("g"); send("3"); send(8'h0A);
        send("4"); send(8'h0D);

        // 4: leading blanks, backspace editing, empty string
        expect_result(32'hAC, 4'd2, 1'b0);
        send(" "); send(" "); send("A"); send("B"); send(8'h08); send("C"); send(8'h0D);
        send("7"); send(8'h08); send(8'h0D);
        repeat (3) @(negedge clk);
        chk("t4_no_output", 64'(bus.out_valid), 64'd0);

        // 5: hold result for 5 cycles with a character waiting
        bus.out_ready = 1'b0;
        expect_result(32'h5A, 4'd2, 1'b0);
        expect_result(32'h9, 4'd1, 1'b0);
        send("5"); send("A"); send(8'h0D);
        bus.in_valid = 1'b1;
        bus.in_char  = "9";
        for (int i = 0; i < 5; i++) begin
            chk("t5_out_valid", 64'(bus.out_valid), 64'd1);
            chk("t5_out_value", 64'(bus.out_value), 64'h5A);
            chk("t5_out_ndigits", 64'(bus.out_ndigits), 64'd2);
            chk("t5_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send("9"); send(8'h0D);

        // 6: asynchronous reset mid-string
        expect_result(32'h7, 4'd1, 1'b0);
        send("1"); send("2");
        chk("t6_pre_ndigits", 64'(bus.out_ndigits), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_value", 64'(bus.out_value), 64'd0);
        chk("t6_rst_ndigits", 64'(bus.out_ndigits), 64'd0);
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send("7"); send(8'h0D);

        repeat (5) @(negedge clk);
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
